pulse_interval_monitor: RTL and testbench
=========================================

# pulse_interval_monitor

Receive-side companion to the periodic pulse generator: watches a single-cycle tick line and measures the clock-cycle interval between successive rising edges. Each interval is compared against an expected period with inclusive tolerance. Errors and missing pulses (timeout) are counted. Sits downstream of the 1 ms tick source (1 MHz clock) as an in-system health monitor and as a synthesizable checker for generator verification.

## Interface
- EXPECTED_INTERVAL, 1000, nominal cycles between rising edges
- TOLERANCE, 10, allowed deviation in cycles, inclusive on both sides
- TIMEOUT, 2000, cycles after the last edge with no new edge before a timeout is declared; must exceed EXPECTED_INTERVAL+TOLERANCE
- CNT_W, 16, interval counter width; must satisfy TIMEOUT < 2^CNT_W
- clk  in  1  system clock (1 MHz nominal)
- rst  in  1  reset, asynchronous, active-high
- en  in  1  monitor enable, level
- clr  in  1  synchronous clear of err_count and pulse_count
- pulse_in  in  1  monitored tick, synchronous to clk
- interval  out  CNT_W  last measured interval, held until next measurement
- meas_valid  out  1  one-cycle strobe, interval/in_range updated
- in_range  out  1  last interval within EXPECTED±TOLERANCE, qualified by meas_valid
- timeout  out  1  one-cycle strobe on missing pulse
- err_count  out  8  out-of-range plus timeout events, saturates at 255
- pulse_count  out  16  rising edges seen while enabled, wraps

## Operation
- Edge detect: rise = pulse_in & ~pulse_d. pulse_d updates every cycle in all states and resets to 1, so a line held high through reset or enable produces no edge. A pulse high for N cycles counts once.
- FSM states: IDLE, WAIT_FIRST, MEASURE.
  - IDLE: cnt=0. en=1 moves to WAIT_FIRST.
  - WAIT_FIRST: on rise, cnt<=0 and go to MEASURE. No measurement is made.
  - MEASURE: cnt increments each cycle.
    - On rise: interval<=cnt+1, meas_valid<=1, in_range<=(EXPECTED-TOL <= cnt+1 <= EXPECTED+TOL), cnt<=0, stay in MEASURE.
    - If cnt+1 == TIMEOUT with no rise: timeout<=1, go to WAIT_FIRST.
- en=0 in any state: go to IDLE next cycle, cnt<=0. No strobes. interval, err_count and pulse_count hold.
- pulse_count increments on each rise in WAIT_FIRST or MEASURE.
- err_count increments on each out-of-range measurement and on each timeout, saturating at 255.
- Priorities:
  - rise beats timeout in the same cycle: measure interval=TIMEOUT, which is out of range.
  - en=0 beats rise.
  - clr beats a same-cycle increment: result is 0.

## Timing
- Reset values: interval=0, meas_valid=0, in_range=0, timeout=0, err_count=0, pulse_count=0, state=IDLE, cnt=0, pulse_d=1. Applied immediately on rst, without a clock edge.
- With rising edges sampled at posedges k1 and k2, interval = k2−k1.
- meas_valid, in_range, interval, err_count and pulse_count all become visible after posedge k2 (one registered stage). meas_valid is high for exactly one cycle.
- timeout is asserted for one cycle, TIMEOUT cycles after the last edge's posedge.
- After a timeout or re-enable, two edges are needed before the next meas_valid.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/header pulse_mon_pkg:
  - FSM state encodings (IDLE=2'd0, WAIT_FIRST=2'd1, MEASURE=2'd2)
  - ERR_CNT_W=8 and the saturation constant
  - Default EXPECTED_INTERVAL/TOLERANCE/TIMEOUT, shared with the generator's bench
- One sub-module, pulse_edge_detect: registers pulse_d with reset value 1 and outputs rise. Everything else stays in the top module.

## Test plan
- Nominal: en=1, pulses every 1000 cycles, 4 pulses -> 3 meas_valid, each interval=1000 and in_range=1; err_count=0; pulse_count=4.
- Tolerance boundaries: successive intervals 990, 1010, 989, 1011 -> in_range 1, 1, 0, 0; err_count=2.
- Timeout: single pulse then silence -> timeout strobe exactly 2000 cycles after the edge; err_count=1. The next pulse gives no meas_valid; a pulse 1000 cycles later gives interval=1000, in_range=1.
- Edge qualification: pulse held high 3 cycles counts once (pulse_count+1). pulse_in high across rst release and en rise produces no edge until it falls and rises again.
- Mid-operation disruption: rst asserted 500 cycles into MEASURE -> all outputs 0 with no clock edge. Separately, en dropped mid-MEASURE -> IDLE with interval/err_count held; after re-enable, the first pulse gives no meas_valid.
- Clear priority: clr asserted in the same cycle as an out-of-range (1100) measurement -> err_count=0 and pulse_count=0. The 256th error leaves err_count at 255.

Source files
------------

// File: rtl/pulse_mon_pkg.sv
// pulse_mon_pkg: shared constants for the tick generator/monitor pair.
// State encodings, error counter sizing and default timing.
package pulse_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_MEAS = 2'd2
  } mon_state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_SAT = '1;

  localparam int DEF_EXPECTED = 1000;
  localparam int DEF_TOLERANCE = 10;
  localparam int DEF_TIMEOUT = 2000;

endpackage

// File: rtl/pulse_edge_detect.sv
// pulse_edge_detect: rising-edge detector for the tick line.
// History resets high so a line already high gives no edge.
module pulse_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse,
  output logic o_rise
);

  logic r_pulse_d;

  // Track the previous sample of the tick line every cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pulse_d <= 1'b1;
    else       r_pulse_d <= i_pulse;
  end

  assign o_rise = i_pulse & ~r_pulse_d;

endmodule

// File: rtl/pulse_interval_monitor.sv
// pulse_interval_monitor: measures cycles between tick edges,
// flags out-of-tolerance intervals and missing ticks.
module pulse_interval_monitor
  import pulse_mon_pkg::*;
#(
  parameter int EXPECTED_INTERVAL = DEF_EXPECTED,
  parameter int TOLERANCE         = DEF_TOLERANCE,
  parameter int TIMEOUT           = DEF_TIMEOUT,
  parameter int CNT_W             = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic                 i_pulse_in,
  output logic [CNT_W-1:0]     o_interval,
  output logic                 o_meas_valid,
  output logic                 o_in_range,
  output logic                 o_timeout,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic [15:0]          o_pulse_count
);

  localparam logic [CNT_W-1:0] LP_LO  =
    CNT_W'(EXPECTED_INTERVAL - TOLERANCE);
  localparam logic [CNT_W-1:0] LP_HI  =
    CNT_W'(EXPECTED_INTERVAL + TOLERANCE);
  localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

  mon_state_t r_state;
  mon_state_t w_state_nxt;

  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_rise;
  logic                 w_meas;
  logic                 w_tmo;
  logic                 w_in_rng;
  logic                 w_pulse_evt;
  logic                 w_err_evt;
  logic                 w_cnt_run;
  logic [CNT_W-1:0]     r_interval;
  logic                 r_meas;
  logic                 r_in_range;
  logic                 r_tmo;
  logic [ERR_CNT_W-1:0] r_err;
  logic [15:0]          r_pcnt;

  pulse_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pulse (i_pulse_in),
    .o_rise  (w_rise)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: disable wins, timeout only when no edge arrives.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_WAIT;
        ST_WAIT: if (w_rise) w_state_nxt = ST_MEAS;
        ST_MEAS:
          if (!w_rise && w_cnt_inc == LP_TMO)
            w_state_nxt = ST_WAIT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-cycle events feeding the registered outputs.
  always_comb begin
    w_meas      = i_en && (r_state == ST_MEAS) && w_rise;
    w_tmo       = i_en && (r_state == ST_MEAS) && !w_rise
                  && (w_cnt_inc == LP_TMO);
    w_in_rng    = (w_cnt_inc >= LP_LO) && (w_cnt_inc <= LP_HI);
    w_pulse_evt = i_en && w_rise
                  && (r_state == ST_WAIT || r_state == ST_MEAS);
    w_err_evt   = (w_meas && !w_in_rng) || w_tmo;
    w_cnt_run   = i_en && (r_state == ST_MEAS) && !w_meas && !w_tmo;
  end

  // Interval counter, strobes, held results and event counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_interval <= '0;
      r_meas     <= 1'b0;
      r_in_range <= 1'b0;
      r_tmo      <= 1'b0;
      r_err      <= '0;
      r_pcnt     <= '0;
    end else begin
      r_cnt  <= w_cnt_run ? w_cnt_inc : '0;
      r_meas <= w_meas;
      r_tmo  <= w_tmo;
      if (w_meas) begin
        r_interval <= w_cnt_inc;
        r_in_range <= w_in_rng;
      end
      if (i_clr) begin
        r_err  <= '0;
        r_pcnt <= '0;
      end else begin
        if (w_err_evt && r_err != ERR_SAT) r_err <= r_err + 1'b1;
        if (w_pulse_evt) r_pcnt <= r_pcnt + 16'd1;
      end
    end
  end

  assign o_interval    = r_interval;
  assign o_meas_valid  = r_meas;
  assign o_in_range    = r_in_range;
  assign o_timeout     = r_tmo;
  assign o_err_count   = r_err;
  assign o_pulse_count = r_pcnt;

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// tb_pulse_interval_monitor: directed checks of interval
// measurement, tolerance, timeout, qualification and priorities.
module tb_pulse_interval_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        pin = 1'b0;
  logic [15:0] interval;
  logic        meas_valid;
  logic        in_range;
  logic        timeout;
  logic [7:0]  err_count;
  logic [15:0] pulse_count;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_interval_monitor dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_clr         (clr),
    .i_pulse_in    (pin),
    .o_interval    (interval),
    .o_meas_valid  (meas_valid),
    .o_in_range    (in_range),
    .o_timeout     (timeout),
    .o_err_count   (err_count),
    .o_pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse; returns just after the posedge that samples it.
  task automatic pulse();
    pin = 1'b1;
    tick();
    pin = 1'b0;
  endtask

  // Pulse whose sampling edge is n cycles after the previous one.
  task automatic gap_pulse(input int n);
    repeat (n - 1) tick();
    pulse();
  endtask

  task automatic chk_meas(input string tag, input int iv,
                          input logic inr);
    chk({tag, ".mv"}, meas_valid, 1);
    chk({tag, ".iv"}, interval, iv);
    chk({tag, ".ir"}, in_range, inr);
  endtask

  int  pc;
  bit  seen;

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst.iv", interval, 0);
    chk("rst.mv", meas_valid, 0);
    chk("rst.ir", in_range, 0);
    chk("rst.to", timeout, 0);
    chk("rst.err", err_count, 0);
    chk("rst.pc", pulse_count, 0);
    tick();
    tick();
    rst = 1'b0;
    en = 1'b1;
    tick();

    // Nominal 1000-cycle ticks.
    pulse();
    chk("nom.first", meas_valid, 0);
    for (int i = 0; i < 3; i++) begin
      gap_pulse(1000);
      chk_meas("nom", 1000, 1'b1);
    end
    tick();
    chk("nom.mv1cyc", meas_valid, 0);
    chk("nom.err", err_count, 0);
    chk("nom.pc", pulse_count, 4);

    // Tolerance boundaries.
    gap_pulse(989);
    chk_meas("tol990", 990, 1'b1);
    gap_pulse(1010);
    chk_meas("tol1010", 1010, 1'b1);
    gap_pulse(989);
    chk_meas("tol989", 989, 1'b0);
    gap_pulse(1011);
    chk_meas("tol1011", 1011, 1'b0);
    chk("tol.err", err_count, 2);
    chk("tol.pc", pulse_count, 8);

    // Timeout after silence.
    seen = 1'b0;
    repeat (1999) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    chk("to.early", seen, 0);
    tick();
    chk("to.strobe", timeout, 1);
    chk("to.err", err_count, 3);
    tick();
    chk("to.1cyc", timeout, 0);
    gap_pulse(300);
    chk("to.first", meas_valid, 0);
    gap_pulse(1000);
    chk_meas("to.after", 1000, 1'b1);

    // Pulse held three cycles counts once.
    pc = int'(pulse_count);
    repeat (999) tick();
    pin = 1'b1;
    tick();
    chk_meas("hold", 1000, 1'b1);
    tick();
    tick();
    pin = 1'b0;
    repeat (5) tick();
    chk("hold.pc", pulse_count, pc + 1);
    chk("hold.mv", meas_valid, 0);

    // Async reset mid-measure, line held high across release.
    repeat (500) tick();
    pin = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.iv", interval, 0);
    chk("arst.err", err_count, 0);
    chk("arst.pc", pulse_count, 0);
    chk("arst.ir", in_range, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    repeat (3) tick();
    chk("held.pc", pulse_count, 0);
    pin = 1'b0;
    tick();
    pulse();
    chk("held.pc1", pulse_count, 1);
    chk("held.mv", meas_valid, 0);
    gap_pulse(1005);
    chk_meas("rearm", 1005, 1'b1);

    // Disable mid-measure, same cycle as an edge.
    repeat (300) tick();
    en = 1'b0;
    pin = 1'b1;
    tick();
    pin = 1'b0;
    chk("dis.mv", meas_valid, 0);
    chk("dis.pc", pulse_count, 2);
    chk("dis.iv", interval, 1005);
    repeat (4) tick();
    chk("dis.to", timeout, 0);
    en = 1'b1;
    tick();
    pulse();
    chk("reen.first", meas_valid, 0);
    chk("reen.pc", pulse_count, 3);
    gap_pulse(1000);
    chk_meas("reen", 1000, 1'b1);

    // Clear beats a same-cycle error and count.
    gap_pulse(1100);
    chk_meas("oor", 1100, 1'b0);
    chk("oor.err", err_count, 1);
    repeat (1099) tick();
    clr = 1'b1;
    pulse();
    clr = 1'b0;
    chk_meas("clr", 1100, 1'b0);
    chk("clr.err", err_count, 0);
    chk("clr.pc", pulse_count, 0);

    // Saturation of the error counter.
    repeat (254) gap_pulse(2);
    chk("sat.254", err_count, 254);
    gap_pulse(2);
    chk("sat.255", err_count, 255);
    gap_pulse(2);
    chk("sat.256", err_count, 255);
    chk("sat.iv", interval, 2);

    // Edge coinciding with the timeout cycle is measured.
    gap_pulse(2000);
    chk_meas("rvt", 2000, 1'b0);
    chk("rvt.to", timeout, 0);
    tick();
    chk("rvt.to2", timeout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
